// File: rtl/actlow_req_encoder.sv
// Active-low request encoder: synchronises N active-low strobes, queues their falling
// edges and offers one binary index at a time on a valid/ready port.
// Optional build macro ROUND_ROBIN_EN selects rotating instead of fixed priority.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no offer outstanding; loads the winning pending index if any
// OFFER | code_o/valid_o held stable until the consumer accepts
module actlow_req_encoder #(
    parameter int N           = 4,
    parameter int W           = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_n,
    output logic [W-1:0] code_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] pend_o,
    output logic         ovf_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] s;
    logic [N-1:0] prev_q;
    logic [N-1:0] fall;
    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic [N-1:0] clr;
    logic         ovf_q;
    logic         ovf_d;
    logic         accept;
    logic         load;
    logic [W-1:0] code_q;
    logic [W-1:0] winner;

    // Idle level of every line is high, so the chain resets to all-1 to avoid a
    // spurious edge right after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            prev_q <= '1;
        end else begin
            sync_q[0] <= req_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~s;

    always_comb begin
        clr = '0;
        if (accept) begin
            clr[code_q] = 1'b1;
        end
    end

    // A new edge on a line being accepted in the same cycle is kept (set wins).
    assign pend_d = (pend_q & ~clr) | fall;
    assign ovf_d  = |(fall & pend_q & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= W'(N - 1);
        end else if (accept) begin
            last_q <= code_q;
        end
    end

    always_comb begin
        logic [W-1:0] idx;
        logic         found;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last_q) + k) % N);
            if (!found && pend_q[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) begin
                winner = W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                code_q <= winner;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pend_q) state_d = OFFER;
            OFFER:   if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_o = (state_q == OFFER);
        load    = (state_q == IDLE) && (|pend_q);
        accept  = (state_q == OFFER) && ready_i;
        code_o  = code_q;
        pend_o  = pend_q;
        ovf_o   = ovf_q;
    end

endmodule
